// File: rtl/dg0045_host_pkg.sv
// rtl/dg0045_host_pkg.sv - shared constants for the DG0045 program ROM host
//
// Purpose : default widths, machine-cycle phase numbers and the NOP opcode
//           used by dg0045_rom_host and dg0045_prog_mem.
// Ports   : none (package).

package dg0045_host_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 8;
   localparam int PC_HALF_W  = 5;

   typedef logic [2:0] phase_t;

   // Phase numbers within the 8-clk machine cycle. Each names the phase whose
   // closing clk edge performs the action.
   localparam phase_t HI_CAP = 3'd1;
   localparam phase_t LO_CAP = 3'd3;
   localparam phase_t RD     = 3'd4;
   localparam phase_t DATA   = 3'd5;
   localparam phase_t STROBE = 3'd6;

   localparam logic [7:0] NOP = 8'h00;

   // The core drives the upper PC half while pc_mux=1, i.e. in phases 0 and 1.
   function automatic logic pc_hi_phase(input phase_t p);
      return (p == 3'd0) || (p == HI_CAP);
   endfunction

   // The memory port is reserved for the fetch read while the read is in flight.
   function automatic logic fetch_busy_phase(input phase_t p);
      return (p == RD) || (p == DATA);
   endfunction

endpackage

// File: rtl/dg0045_prog_mem.sv
// rtl/dg0045_prog_mem.sv - single-port program RAM, sync write, sync read, write-first
//
// Purpose : program store for the DG0045 core. One shared address port;
//           a write also returns the written byte on rdata.
// Ports   : clk   - clock
//           en    - port enable (read or write this edge)
//           we    - write enable (qualified by en)
//           addr  - word address
//           wdata - write byte
//           rdata - registered read byte, holds when en=0
// Contents are not reset.

module dg0045_prog_mem
   import dg0045_host_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
         end else begin
            rdata     <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dg0045_rom_host.sv
// rtl/dg0045_rom_host.sv - program ROM host for the DG0045 core with load port
//
// Purpose : rebuilds the core's multiplexed program counter, fetches the
//           instruction byte once per 8-clk machine cycle and lets a host
//           load the program RAM between fetches.
// Ports   : clk          - clock shared with the core
//           rst_n        - synchronous active-low reset
//           pc_hl        - PC half from the core ({PU,PL[5]} or PL[4:0])
//           pc_mux       - half select to the core, 1 = upper half
//           rom_data     - instruction byte to the core
//           fetch_addr   - captured fetch address {hi_reg,lo_reg}
//           fetch_strobe - one-clk pulse after rom_data updates
//           load_valid   - program-load write request
//           load_ready   - write slot available
//           load_addr    - program-load address
//           load_data    - program-load byte
//           load_mode    - feed NOPs to the core while loading

module dg0045_rom_host
   import dg0045_host_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        pc_hl,
   output logic              pc_mux,
   output logic [DATA_W-1:0] rom_data,
   output logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_strobe,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_mode
);

   localparam int HI_W = ADDR_W - PC_HALF_W;

   phase_t                p;
   logic [HI_W-1:0]       hi_reg;
   logic [PC_HALF_W-1:0]  lo_reg;
   logic                  wr_en;
   logic                  rd_en;
   logic                  mem_en;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_rdata;

   // Machine-cycle phase; reset parks it at 0 so the first released edge
   // enters phase 1 and the aborted fetch is simply dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p <= 3'd0;
      end else begin
         p <= p + 3'd1;
      end
   end

   assign pc_mux = pc_hi_phase(p);

   // PC halves are sampled only on their capture edges; pc_hl is ignored
   // everywhere else.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_reg <= '0;
         lo_reg <= '0;
      end else begin
         if (p == HI_CAP) begin
            hi_reg <= pc_hl[HI_W-1:0];
         end
         if (p == LO_CAP) begin
            lo_reg <= pc_hl;
         end
      end
   end

   assign fetch_addr = {hi_reg, lo_reg};

   // The load port shares the single RAM port with the fetch. It is closed
   // while the read is in flight, so a stalled writer lands on the p=6 edge.
   // Writes earlier in the cycle reach the array before the p=4 read and are
   // therefore seen by the same cycle's fetch.
   assign load_ready = rst_n && !fetch_busy_phase(p);
   assign wr_en      = load_valid && load_ready;
   assign rd_en      = rst_n && (p == RD);
   assign mem_en     = wr_en || rd_en;
   assign mem_addr   = wr_en ? load_addr : fetch_addr;

   dg0045_prog_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_prog_mem (
      .clk   (clk),
      .en    (mem_en),
      .we    (wr_en),
      .addr  (mem_addr),
      .wdata (load_data),
      .rdata (mem_rdata)
   );

   // Output byte changes only on the edge ending p=5; load_mode substitutes a
   // NOP so the core idles without disturbing the phase schedule.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rom_data     <= DATA_W'(NOP);
         fetch_strobe <= 1'b0;
      end else begin
         if (p == DATA) begin
            rom_data <= load_mode ? DATA_W'(NOP) : mem_rdata;
         end
         fetch_strobe <= (p == DATA);
      end
   end

endmodule

// File: tb/tb_dg0045_rom_host.sv
// tb/tb_dg0045_rom_host.sv - scoreboard testbench for dg0045_rom_host

module tb_dg0045_rom_host;

   typedef struct {
      logic [9:0] addr;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] pc_hl;
   logic       pc_mux;
   logic [7:0] rom_data;
   logic [9:0] fetch_addr;
   logic       fetch_strobe;
   logic       load_valid;
   logic       load_ready;
   logic [9:0] load_addr;
   logic [7:0] load_data;
   logic       load_mode;

   int vectors     = 0;
   int miscompares = 0;

   exp_t       sb[$];
   logic [7:0] mem_model [0:1023];
   logic [2:0] tp     = 3'd0;
   logic       in_rst = 1'b1;
   logic [9:0] cur_addr;
   logic [7:0] last_data = 8'h00;
   logic [9:0] addr_list [0:5];

   always #5 clk = ~clk;

   dg0045_rom_host dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_hl        (pc_hl),
      .pc_mux       (pc_mux),
      .rom_data     (rom_data),
      .fetch_addr   (fetch_addr),
      .fetch_strobe (fetch_strobe),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .load_mode    (load_mode)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference phase; a reset edge aborts whatever fetch was pending.
   always @(posedge clk) begin
      if (!rst_n) begin
         tp     <= 3'd0;
         in_rst <= 1'b1;
         sb.delete();
      end else begin
         tp     <= tp + 3'd1;
         in_rst <= 1'b0;
      end
   end

   // Core model: present the correct PC half only on the capture edges and
   // noise elsewhere.
   always @(negedge clk) begin
      if (tp == 3'd1)      pc_hl = cur_addr[9:5];
      else if (tp == 3'd3) pc_hl = cur_addr[4:0];
      else                 pc_hl = 5'($urandom);
   end

   // Producer and checker, sampled 1 time unit after the active edge.
   always @(posedge clk) begin
      #1;
      if (in_rst) begin
         last_data = 8'h00;
         check("rst_rom_data",   32'(rom_data),     32'h00);
         check("rst_strobe",     32'(fetch_strobe), 32'h0);
         check("rst_pc_mux",     32'(pc_mux),       32'h1);
         check("rst_load_ready", 32'(load_ready),   32'h0);
         check("rst_fetch_addr", 32'(fetch_addr),   32'h0);
      end else begin
         check("pc_mux",     32'(pc_mux),       32'(tp < 3'd2));
         check("load_ready", 32'(load_ready),   32'(rst_n && tp != 3'd4 && tp != 3'd5));
         check("strobe",     32'(fetch_strobe), 32'(tp == 3'd6));
         if (tp == 3'd4) begin
            exp_t e;
            e.addr = cur_addr;
            e.data = load_mode ? 8'h00 : mem_model[cur_addr];
            sb.push_back(e);
         end
         if (fetch_strobe) begin
            check("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               check("fetch_addr", 32'(fetch_addr), 32'(e.addr));
               check("rom_data",   32'(rom_data),   32'(e.data));
               last_data = e.data;
            end
         end else begin
            check("rom_hold", 32'(rom_data), 32'(last_data));
         end
      end
   end

   task automatic wait_phase(input logic [2:0] ph);
      int n = 0;
      @(negedge clk);
      while (tp != ph && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (tp != ph) check("wait_phase", 32'(tp), 32'(ph));
   endtask

   task automatic fetch(input logic [9:0] a, input logic m);
      wait_phase(3'd0);
      cur_addr  = a;
      load_mode = m;
   endtask

   // Called at a negedge; returns at a negedge with load_valid low.
   task automatic write(input logic [9:0] a, input logic [7:0] d, output int ph);
      bit done = 1'b0;
      ph         = -1;
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      for (int n = 0; n < 16 && !done; n++) begin
         if (load_ready) begin
            ph = int'(tp);
            @(posedge clk);
            mem_model[a] = d;
            done = 1'b1;
         end
         @(negedge clk);
      end
      load_valid = 1'b0;
      check("write_done", 32'(done), 32'h1);
   endtask

   initial begin
      int ph;
      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_addr  = '0;
      load_data  = '0;
      load_mode  = 1'b1;
      cur_addr   = '0;
      pc_hl      = '0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;

      // Preload while the core is fed NOPs.
      write(10'h000, 8'h02, ph);
      write(10'h2CB, 8'hC5, ph);
      write(10'h155, 8'h11, ph);
      write(10'h0AA, 8'h3C, ph);
      for (int i = 0; i < 6; i++) begin
         addr_list[i] = 10'($urandom);
         write(addr_list[i], 8'($urandom), ph);
      end

      fetch(10'h000, 1'b0);
      fetch(10'h2CB, 1'b0);
      for (int i = 0; i < 6; i++) fetch(addr_list[i], 1'b0);

      // NOP substitution, then normal data again.
      fetch(10'h2CB, 1'b1);
      fetch(10'h2CB, 1'b0);

      // Write stalled across the read; old byte this cycle, new byte next.
      fetch(10'h155, 1'b0);
      wait_phase(3'd4);
      write(10'h155, 8'hA7, ph);
      check("stall_write_phase", 32'(ph), 32'd6);
      fetch(10'h155, 1'b0);

      // Write to the address being fetched before the read.
      fetch(10'h2CB, 1'b0);
      wait_phase(3'd2);
      write(10'h2CB, 8'h5E, ph);
      check("wbr_write_phase", 32'(ph), 32'd2);

      // Reset in the middle of a fetch.
      fetch(10'h0AA, 1'b0);
      wait_phase(3'd5);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      cur_addr = 10'h2CB;
      rst_n    = 1'b1;
      wait_phase(3'd7);

      fetch(10'h0AA, 1'b0);
      wait_phase(3'd7);
      check("sb_left", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dg0045_rom_host.md
DG0045_ROM_HOST -- requirements
Module: dg0045_rom_host

Interface
REQ-001 Parameter ADDR_W, default 10, program address width ({PU,PL}).
REQ-002 Parameter DATA_W, default 8, instruction width.
REQ-003 clk  input  1  single clock, rising edge, same clock as the DG0045 core.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 pc_hl  input  5  multiplexed program-counter half from the core.
REQ-006 pc_mux  output  1  half select to the core: 1 = {PU,PL[5]}, 0 = PL[4:0].
REQ-007 rom_data  output  8  instruction byte to the core's ui_in.
REQ-008 fetch_addr  output  10  captured fetch address, {hi_reg,lo_reg}.
REQ-009 fetch_strobe  output  1  one-clk pulse: rom_data updated.
REQ-010 load_valid  input  1  program-load write request.
REQ-011 load_ready  output  1  write slot available.
REQ-012 load_addr  input  10  program-load address.
REQ-013 load_data  input  8  program-load byte.
REQ-014 load_mode  input  1  1 = core held on NOP while program is loaded.

Function
REQ-015 A 3-bit phase counter p SHALL increment every clk, wrapping 7->0; one wrap = one machine cycle (8 clk).
REQ-016 pc_mux SHALL be 1 while p in {0,1} and 0 while p in {2..7}, decoded from p.
REQ-017 hi_reg SHALL capture pc_hl on the clk edge ending p=1; lo_reg on the clk edge ending p=3.
REQ-018 fetch_addr SHALL equal {hi_reg,lo_reg}, MSB first; no arithmetic, no wrap.
REQ-019 A synchronous memory read of fetch_addr SHALL be issued in p=4; data valid in p=5.
REQ-020 rom_data SHALL register on the edge ending p=5, stable from p=6 through p=5 of the next cycle.
REQ-021 fetch_strobe SHALL be 1 exactly during p=6.
REQ-022 load_mode=1 at the p=5 edge SHALL load rom_data with 8'h00 (NOP) instead of memory data; phase and pc_mux schedule unchanged.
REQ-023 load_ready SHALL be 1 when rst_n=1 and p not in {4,5}; 0 otherwise.
REQ-024 A write SHALL occur on any edge with load_valid=1 and load_ready=1: mem[load_addr] <= load_data.
REQ-025 load_valid held across p=4/5 SHALL stall; the write completes on the first ready edge (p=6); load_addr/load_data held by the source.
REQ-026 Write to the current fetch address before p=4 SHALL be returned by that cycle's read (write-before-read).
REQ-027 pc_hl changes outside the capture edges SHALL have no effect.

Reset
REQ-028 With rst_n=0 at a clk edge: p=0, hi_reg=0, lo_reg=0, rom_data=8'h00, fetch_strobe=0, write suppressed.
REQ-029 During reset pc_mux SHALL be 1 (p=0) and load_ready 0; memory contents SHALL NOT be cleared.
REQ-030 Reset mid-cycle SHALL abort the fetch; first clk after release is p=1, first strobe at p=6 of the first cycle.

Structure
REQ-031 Package dg0045_host_pkg SHALL hold ADDR_W/DATA_W defaults, phase constants (HI_CAP=1, LO_CAP=3, RD=4, DATA=5, STROBE=6) and NOP=8'h00.
REQ-032 Sub-module dg0045_prog_mem SHALL implement 1024x8 single-port RAM, sync write, sync read, write-first.
REQ-033 Phase counter, capture registers, load arbitration and output register SHALL reside in dg0045_rom_host.

Verification
REQ-034 Reset, preload mem[0x000]=0x02, pc_hl=0 -> rom_data=0x02 at p=6, fetch_strobe one clk.
REQ-035 pc_hl=5'b10110 in p0-1, 5'b01011 in p2-7, mem[0x2CB]=0xC5 -> fetch_addr=0x2CB, rom_data=0xC5.
REQ-036 load_valid asserted at p=4 -> load_ready 0 in p4,p5; write lands at p=6 edge; readback next cycle correct.
REQ-037 load_mode=1 with mem[addr]=0xC5 -> rom_data=0x00; load_mode=0 next cycle -> 0xC5.
REQ-038 rst_n=0 at p=5 -> rom_data=0x00, load_ready=0, pc_mux=1; after release strobe at p=6 with new data.
REQ-039 Write 0x5E to 0x2CB at p=2 while fetching 0x2CB -> rom_data=0x5E same cycle.
